// File: rtl/hash_map_pkg.sv
// Shared encodings for the chained hash map: operation select, error codes
// and the controller state type.
package hash_map_pkg;

  typedef enum logic [1:0] {
    OpInsert = 2'b00,
    OpDelete = 2'b01,
    OpSearch = 2'b10,
    OpClear  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'b00,
    ErrFull     = 2'b01,
    ErrNotFound = 2'b10
  } err_e;

  typedef enum logic [2:0] {
    StIdle,
    StWalk,
    StExec,
    StDone,
    StClr
  } state_e;

endpackage

// File: rtl/hash_index_fn.sv
// Combinational bucket index for the chained hash map.
// Ports:
//   key_i   - key to hash
//   index_o - bucket index, log2(TOTAL_INDEX) bits
// MODULUS takes the low bits (TOTAL_INDEX is a power of two); XOR_FOLD xors
// every index-wide slice of the key, with the top slice zero-padded.
module hash_index_fn #(
  parameter int unsigned KEY_WIDTH      = 32,
  parameter int unsigned TOTAL_INDEX    = 8,
  parameter string       HASH_ALGORITHM = "MODULUS"
) (
  input  logic [KEY_WIDTH-1:0]           key_i,
  output logic [$clog2(TOTAL_INDEX)-1:0] index_o
);

  localparam int unsigned IdxW   = $clog2(TOTAL_INDEX);
  localparam int unsigned NSlice = (KEY_WIDTH + IdxW - 1) / IdxW;
  localparam int unsigned PadW   = NSlice * IdxW;

  logic [PadW-1:0] key_pad;
  assign key_pad = PadW'(key_i);

  if (HASH_ALGORITHM == "XOR_FOLD") begin : g_xor_fold
    always_comb begin
      index_o = '0;
      for (int i = 0; i < int'(NSlice); i++) begin
        index_o = index_o ^ key_pad[i*IdxW +: IdxW];
      end
    end
  end else begin : g_modulus
    assign index_o = key_pad[IdxW-1:0];
    if (PadW > IdxW) begin : g_unused
      logic unused_key_hi;
      assign unused_key_hi = ^key_pad[PadW-1:IdxW];
    end
  end

endmodule

// File: rtl/chained_hash_map.sv
// Hash map with TOTAL_INDEX buckets of CHAINING_SIZE slots each.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   key_in, value_in - operation key / insert value, latched on acceptance
//   op_sel, op_en    - operation (insert/delete/search/clear) and request valid
//   op_ready         - idle; a request with op_en is accepted on this edge
//   op_done          - one-cycle completion pulse
//   value_out, op_error, error_code, collision_count
//                    - result of the last completed op, held until the next
//   entry_count      - total valid entries
// Every lookup walks all slots of the bucket one per cycle, so latency is
// fixed at CHAINING_SIZE+2 cycles (clear-all: 2 cycles).
module chained_hash_map
  import hash_map_pkg::*;
#(
  parameter int unsigned KEY_WIDTH      = 32,
  parameter int unsigned VALUE_WIDTH    = 32,
  parameter int unsigned TOTAL_INDEX    = 8,
  parameter int unsigned CHAINING_SIZE  = 4,
  parameter string       HASH_ALGORITHM = "MODULUS"
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [KEY_WIDTH-1:0]                            key_in,
  input  logic [VALUE_WIDTH-1:0]                          value_in,
  input  logic [1:0]                                      op_sel,
  input  logic                                            op_en,
  output logic                                            op_ready,
  output logic [VALUE_WIDTH-1:0]                          value_out,
  output logic                                            op_done,
  output logic                                            op_error,
  output logic [1:0]                                      error_code,
  output logic [$clog2(CHAINING_SIZE+1)-1:0]              collision_count,
  output logic [$clog2(TOTAL_INDEX*CHAINING_SIZE+1)-1:0]  entry_count
);

  localparam int unsigned IdxW  = $clog2(TOTAL_INDEX);
  localparam int unsigned SlotW = $clog2(CHAINING_SIZE);
  localparam int unsigned CcW   = $clog2(CHAINING_SIZE + 1);
  localparam int unsigned EcW   = $clog2(TOTAL_INDEX * CHAINING_SIZE + 1);
  // Flat storage addressed by {bucket, slot}; unused slot codes stay invalid.
  localparam int unsigned Depth = TOTAL_INDEX << SlotW;

  localparam logic [SlotW-1:0] LastSlot   = SlotW'(CHAINING_SIZE - 1);
  localparam logic [EcW-1:0]   EntriesMax = EcW'(TOTAL_INDEX * CHAINING_SIZE);

  state_e state_q, state_d;

  // Latched request
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] val_q;
  op_e                    op_q;
  logic [IdxW-1:0]        bucket_q;

  // Walk bookkeeping
  logic [SlotW-1:0] walk_q;
  logic             hit_q, free_q;
  logic [SlotW-1:0] hit_slot_q, free_slot_q;
  logic [CcW-1:0]   occ_q;

  // Table storage
  logic [KEY_WIDTH-1:0]   key_mem_q [Depth];
  logic [VALUE_WIDTH-1:0] val_mem_q [Depth];
  logic [Depth-1:0]       valid_q;

  // Result staged in EXEC/CLR, published together with op_done
  logic [VALUE_WIDTH-1:0] res_val_q;
  err_e                   res_err_q;
  logic [CcW-1:0]         res_coll_q;

  logic [VALUE_WIDTH-1:0] value_out_q;
  err_e                   err_q;
  logic [CcW-1:0]         coll_q;
  logic [EcW-1:0]         entry_q;
  logic                   op_done_q;

  logic [IdxW-1:0]       hash_idx;
  logic [IdxW+SlotW-1:0] cur_idx, hit_idx, free_idx;
  logic                  cur_valid, cur_match;
  logic                  accept;

  hash_index_fn #(
    .KEY_WIDTH      (KEY_WIDTH),
    .TOTAL_INDEX    (TOTAL_INDEX),
    .HASH_ALGORITHM (HASH_ALGORITHM)
  ) u_hash (
    .key_i   (key_in),
    .index_o (hash_idx)
  );

  assign accept    = op_en && (state_q == StIdle);
  assign cur_idx   = {bucket_q, walk_q};
  assign hit_idx   = {bucket_q, hit_slot_q};
  assign free_idx  = {bucket_q, free_slot_q};
  assign cur_valid = valid_q[cur_idx];
  assign cur_match = cur_valid && (key_mem_q[cur_idx] == key_q);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (op_en) begin
          state_d = (op_e'(op_sel) == OpClear) ? StClr : StWalk;
        end
      end
      StWalk:  if (walk_q == LastSlot) state_d = StExec;
      StExec:  state_d = StDone;
      StClr:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    op_ready = (state_q == StIdle);
  end

  assign value_out       = value_out_q;
  assign op_done         = op_done_q;
  assign error_code      = err_q;
  assign op_error        = (err_q != ErrNone);
  assign collision_count = coll_q;
  assign entry_count     = entry_q;

  // Table and key/value memories; written only in EXEC/CLR, so a reset
  // during WALK leaves no partial update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (state_q == StClr) begin
      valid_q <= '0;
    end else if (state_q == StExec) begin
      unique case (op_q)
        OpInsert: begin
          if (hit_q) begin
            val_mem_q[hit_idx] <= val_q;
          end else if (free_q) begin
            key_mem_q[free_idx] <= key_q;
            val_mem_q[free_idx] <= val_q;
            valid_q[free_idx]   <= 1'b1;
          end
        end
        OpDelete: if (hit_q) valid_q[hit_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Request latch, walk bookkeeping, results and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      val_q       <= '0;
      op_q        <= OpInsert;
      bucket_q    <= '0;
      walk_q      <= '0;
      hit_q       <= 1'b0;
      free_q      <= 1'b0;
      hit_slot_q  <= '0;
      free_slot_q <= '0;
      occ_q       <= '0;
      res_val_q   <= '0;
      res_err_q   <= ErrNone;
      res_coll_q  <= '0;
      value_out_q <= '0;
      err_q       <= ErrNone;
      coll_q      <= '0;
      entry_q     <= '0;
      op_done_q   <= 1'b0;
    end else begin
      op_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            key_q    <= key_in;
            val_q    <= value_in;
            op_q     <= op_e'(op_sel);
            bucket_q <= hash_idx;
            walk_q   <= '0;
            hit_q    <= 1'b0;
            free_q   <= 1'b0;
            occ_q    <= '0;
          end
        end
        StWalk: begin
          walk_q <= walk_q + SlotW'(1);
          // Keep only the first match and the lowest free slot.
          if (cur_match && !hit_q) begin
            hit_q      <= 1'b1;
            hit_slot_q <= walk_q;
          end
          if (!cur_valid && !free_q) begin
            free_q      <= 1'b1;
            free_slot_q <= walk_q;
          end
          if (cur_valid) occ_q <= occ_q + CcW'(1);
        end
        StExec: begin
          res_val_q  <= '0;
          res_err_q  <= ErrNone;
          res_coll_q <= occ_q;
          unique case (op_q)
            OpInsert: begin
              if (!hit_q && free_q) begin
                res_coll_q <= occ_q + CcW'(1);
                if (entry_q != EntriesMax) entry_q <= entry_q + EcW'(1);
              end else if (!hit_q) begin
                res_err_q <= ErrFull;
              end
            end
            OpDelete: begin
              if (hit_q) begin
                res_coll_q <= occ_q - CcW'(1);
                if (entry_q != '0) entry_q <= entry_q - EcW'(1);
              end else begin
                res_err_q <= ErrNotFound;
              end
            end
            OpSearch: begin
              if (hit_q) res_val_q <= val_mem_q[hit_idx];
              else       res_err_q <= ErrNotFound;
            end
            default: ;
          endcase
        end
        StClr: begin
          res_val_q  <= '0;
          res_err_q  <= ErrNone;
          res_coll_q <= '0;
          entry_q    <= '0;
        end
        StDone: begin
          op_done_q   <= 1'b1;
          value_out_q <= res_val_q;
          err_q       <= res_err_q;
          coll_q      <= res_coll_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chained_hash_map.sv
module tb_chained_hash_map;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] key_in, value_in;
  logic [1:0]  op_sel;
  logic        op_en;
  logic        op_ready;
  logic [31:0] value_out;
  logic        op_done, op_error;
  logic [1:0]  error_code;
  logic [2:0]  collision_count;
  logic [5:0]  entry_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    int          lat;
    int          acc;
    bit          chk_val;
    logic [31:0] val;
    logic [1:0]  err;
    int          coll;
    int          entry;
  } exp_t;

  exp_t exp_q[$];

  chained_hash_map dut (
    .clk             (clk),
    .rst             (rst),
    .key_in          (key_in),
    .value_in        (value_in),
    .op_sel          (op_sel),
    .op_en           (op_en),
    .op_ready        (op_ready),
    .value_out       (value_out),
    .op_done         (op_done),
    .op_error        (op_error),
    .error_code      (error_code),
    .collision_count (collision_count),
    .entry_count     (entry_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && op_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_op_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".latency"}, cyc - e.acc, e.lat);
        check({e.name, ".error_code"}, int'(error_code), int'(e.err));
        check({e.name, ".op_error"}, int'(op_error), int'(e.err != 2'b00));
        check({e.name, ".collision_count"}, int'(collision_count), e.coll);
        check({e.name, ".entry_count"}, int'(entry_count), e.entry);
        if (e.chk_val) check({e.name, ".value_out"}, int'(value_out), int'(e.val));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, ".timeout"}, 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] k,
                       input logic [31:0] v, input bit chk_val, input logic [31:0] ev,
                       input logic [1:0] eerr, input int ecoll, input int eent);
    exp_t e;
    wait_ready();
    key_in   = k;
    value_in = v;
    op_sel   = op;
    op_en    = 1'b1;
    @(posedge clk);
    #1;
    op_en     = 1'b0;
    e.name    = name;
    e.lat     = (op == 2'b11) ? 2 : 6;
    e.acc     = cyc;
    e.chk_val = chk_val;
    e.val     = ev;
    e.err     = eerr;
    e.coll    = ecoll;
    e.entry   = eent;
    exp_q.push_back(e);
    wait_drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1; op_en = 1'b0; op_sel = 2'b00; key_in = '0; value_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.op_ready", int'(op_ready), 1);
    check("reset.op_done", int'(op_done), 0);
    check("reset.entry_count", int'(entry_count), 0);
    check("reset.error_code", int'(error_code), 0);
    check("reset.value_out", int'(value_out), 0);
    check("reset.collision_count", int'(collision_count), 0);

    // Basic insert and search
    do_op("ins_1_2",    2'b00, 1, 2, 0, 0, 2'b00, 1, 1);
    do_op("srch_1",     2'b10, 1, 0, 1, 2, 2'b00, 1, 1);
    // Clear-all, then the old key is gone
    do_op("clear_a",    2'b11, 0, 0, 1, 0, 2'b00, 0, 0);
    do_op("srch_1_clr", 2'b10, 1, 0, 1, 0, 2'b10, 0, 0);

    // Fill bucket 3, then overflow it
    do_op("ins_3",      2'b00, 3,  3,  0, 0, 2'b00, 1, 1);
    do_op("ins_11",     2'b00, 11, 11, 0, 0, 2'b00, 2, 2);
    do_op("ins_19",     2'b00, 19, 19, 0, 0, 2'b00, 3, 3);
    do_op("ins_27",     2'b00, 27, 27, 0, 0, 2'b00, 4, 4);
    do_op("ins_35_full",2'b00, 35, 9,  0, 0, 2'b01, 4, 4);

    // Delete leaves a hole that the next insert reuses
    do_op("del_11",     2'b01, 11, 0, 0, 0, 2'b00, 3, 3);
    do_op("ins_35",     2'b00, 35, 9, 0, 0, 2'b00, 4, 4);
    do_op("srch_35",    2'b10, 35, 0, 1, 9, 2'b00, 4, 4);
    do_op("srch_11",    2'b10, 11, 0, 1, 0, 2'b10, 4, 4);
    do_op("del_11_miss",2'b01, 11, 0, 0, 0, 2'b10, 4, 4);

    // Overwrite existing key
    do_op("ins_3_ovw",  2'b00, 3, 5, 0, 0, 2'b00, 4, 4);
    do_op("srch_3",     2'b10, 3, 0, 1, 5, 2'b00, 4, 4);
    do_op("srch_19",    2'b10, 19, 0, 1, 19, 2'b00, 4, 4);

    // op_en held high while busy: exactly one completion
    wait_ready();
    key_in = 7; value_in = 8; op_sel = 2'b00; op_en = 1'b1;
    @(posedge clk);
    #1;
    e.name = "ins_7_held"; e.lat = 6; e.acc = cyc; e.chk_val = 0; e.val = 0;
    e.err = 2'b00; e.coll = 1; e.entry = 5;
    exp_q.push_back(e);
    repeat (4) @(posedge clk);
    #1 op_en = 1'b0;
    wait_drain("ins_7_held");
    repeat (10) @(negedge clk);
    do_op("srch_7",     2'b10, 7, 0, 1, 8, 2'b00, 1, 5);

    // Reset during WALK aborts the insert
    wait_ready();
    key_in = 5; value_in = 7; op_sel = 2'b00; op_en = 1'b1;
    @(posedge clk);
    #1 op_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_walk.op_ready", int'(op_ready), 1);
    check("rst_walk.entry_count", int'(entry_count), 0);
    check("rst_walk.op_done", int'(op_done), 0);
    check("rst_walk.error_code", int'(error_code), 0);
    repeat (10) @(negedge clk);
    do_op("srch_5_rst", 2'b10, 5, 0, 1, 0, 2'b10, 0, 0);
    do_op("srch_3_rst", 2'b10, 3, 0, 1, 0, 2'b10, 0, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chained_hash_map.md
CHAINED_HASH_MAP -- requirements
Module: chained_hash_map

Interface
REQ-001 The block SHALL have parameter KEY_WIDTH, default 32, key bit width.
REQ-002 The block SHALL have parameter VALUE_WIDTH, default 32, value bit width.
REQ-003 The block SHALL have parameter TOTAL_INDEX, default 8, bucket count, power of two, >= 2.
REQ-004 The block SHALL have parameter CHAINING_SIZE, default 4, slots per bucket, >= 2.
REQ-005 The block SHALL have parameter HASH_ALGORITHM, default "MODULUS", with legal values "MODULUS" and "XOR_FOLD".
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 The ports SHALL be, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- key_in  in  KEY_WIDTH  operation key.
- value_in  in  VALUE_WIDTH  insert value.
- op_sel  in  2  00 insert, 01 delete, 10 search, 11 clear-all.
- op_en  in  1  request valid.
- op_ready  out  1  idle, request accepted.
- value_out  out  VALUE_WIDTH  search result.
- op_done  out  1  one-cycle completion pulse.
- op_error  out  1  operation failed.
- error_code  out  2  00 none, 01 full, 10 not-found.
- collision_count  out  clog2(CHAINING_SIZE+1)  valid entries in the target bucket after the op.
- entry_count  out  clog2(TOTAL_INDEX*CHAINING_SIZE+1)  total valid entries.

Function
REQ-008 A request SHALL be accepted on a rising edge where op_en=1 and op_ready=1; key_in, value_in and op_sel SHALL be latched at that edge.
REQ-009 op_ready SHALL be 0 from acceptance until the edge on which op_done is driven high; op_en while busy SHALL be ignored.
REQ-010 Hash under MODULUS SHALL be key mod TOTAL_INDEX.
REQ-011 Hash under XOR_FOLD SHALL be the XOR of all log2(TOTAL_INDEX)-bit slices of the key, with the top slice zero-padded.
REQ-012 The FSM states SHALL be IDLE -> WALK -> EXEC -> DONE -> IDLE for ops 00, 01 and 10, and IDLE -> CLR -> DONE -> IDLE for op 11.
REQ-013 WALK SHALL examine one slot per cycle for exactly CHAINING_SIZE cycles, recording the first matching valid slot and the first free slot.
REQ-014 op_done SHALL be high for exactly one cycle, CHAINING_SIZE+2 cycles after acceptance (ops 00/01/10) or 2 cycles after acceptance (op 11); latency SHALL be independent of data.
REQ-015 Insert on a hit SHALL overwrite the value, with error_code=00.
REQ-016 Insert on a miss with a free slot SHALL write the lowest free slot.
REQ-017 Insert on a miss with the bucket full SHALL leave the table unchanged and report op_error=1, error_code=01.
REQ-018 Delete on a hit SHALL clear that slot's valid bit, leaving a hole that later inserts reuse.
REQ-019 Delete on a miss SHALL report error_code=10.
REQ-020 Search on a hit SHALL drive value_out with the stored value; on a miss it SHALL drive value_out=0 and error_code=10.
REQ-021 Clear-all SHALL invalidate every slot, report error_code=00, and set collision_count=0.
REQ-022 value_out, op_error, error_code and collision_count SHALL be valid while op_done=1 and SHALL hold until the next op_done.
REQ-023 entry_count SHALL update in the EXEC/CLR cycle and SHALL never wrap.
REQ-024 op_error SHALL equal (error_code != 00).

Reset
REQ-025 On rst=1 at a clock edge, all valid bits, value_out, op_done, op_error, error_code, collision_count and entry_count SHALL be cleared, op_ready SHALL be 1, and the FSM SHALL be in IDLE.
REQ-026 Reset mid-operation SHALL abort that operation with no op_done pulse and no partial write.
REQ-027 Reset SHALL take priority over op_en.

Structure
REQ-028 Package hash_map_pkg SHALL hold the op_sel encoding, the error_code encoding and the FSM state typedef.
REQ-029 Hash computation SHALL be the combinational sub-module hash_index_fn, parameterised by KEY_WIDTH, TOTAL_INDEX and HASH_ALGORITHM.
REQ-030 Key, value and valid storage SHALL be flat registers indexed by {bucket, slot}.

Verification
REQ-031 The bench SHALL cover: insert(1,2), then search(1) -> value_out=2, error_code=00, collision_count=1, op_done at acceptance+6 with defaults.
REQ-032 The bench SHALL cover: insert keys 3, 11, 19, 27 (bucket 3 under MODULUS), then insert(35,9) -> op_error=1, error_code=01, entry_count=4.
REQ-033 The bench SHALL cover: delete(11), insert(35,9), search(35) -> value_out=9, collision_count=4; search(11) -> error_code=10, value_out=0.
REQ-034 The bench SHALL cover: insert(3,5) when key 3 is present -> error_code=00, entry_count unchanged, search(3)=5.
REQ-035 The bench SHALL cover: clear-all -> op_done 2 cycles after acceptance, entry_count=0, and search of any previously inserted key -> error_code=10.
REQ-036 The bench SHALL cover: rst asserted during the WALK of an insert -> no op_done, op_ready=1, entry_count=0; and op_en held while busy -> exactly one op_done per accepted request.
